// File: rtl/booth_sign_pipe.sv
// booth_sign_pipe
//   Carries the product sign and zero flag of each Booth operand pair through
//   a DEPTH-stage pipeline that runs alongside the partial-product datapath.
//   Each accepted beat is stamped with a wrapping sequence tag.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        synchronous, active-high reset
//   in_valid     upstream beat valid
//   in_ready     beat accepted this cycle when in_valid & in_ready
//   in_a, in_b   LANES operands of W bits, lane i at [i*W +: W]
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled per beat)
//   flush        discard every in-flight beat; blocks acceptance this cycle
//   out_valid    output beat valid
//   out_ready    downstream accepts the output beat
//   out_sign     per-lane product sign
//   out_zero     per-lane product-is-zero flag
//   out_seq      sequence tag of the output beat
module booth_sign_pipe #(
  parameter int LANES = 4,
  parameter int W     = 8,
  parameter int DEPTH = 3,
  parameter int SEQW  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  input  logic                 signed_mode,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES-1:0]     out_sign,
  output logic [LANES-1:0]     out_zero,
  output logic [SEQW-1:0]      out_seq
);

  logic [LANES-1:0] lane_sign;
  logic [LANES-1:0] lane_zero;

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] load;
  logic [LANES-1:0] sign_q [DEPTH];
  logic [LANES-1:0] zero_q [DEPTH];
  logic [SEQW-1:0]  seq_q  [DEPTH];
  logic [SEQW-1:0]  seq_cnt;
  logic             accept;

  // Sign only matters for a non-zero product; unsigned operands never negate.
  always_comb begin
    lane_sign = '0;
    lane_zero = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_zero[i] = (in_a[i*W +: W] == '0) | (in_b[i*W +: W] == '0);
      lane_sign[i] = signed_mode & (in_a[i*W+W-1] ^ in_b[i*W+W-1]) & ~lane_zero[i];
    end
  end

  // Stage k can take new contents when the output is being drained or any
  // stage from k to the end holds a bubble. Computed as a running OR from
  // the output end so no bit depends on another bit of the same vector.
  always_comb begin
    logic room;
    room = out_ready;
    load = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      room    = room | ~vld[k];
      load[k] = room;
    end
  end

  assign in_ready = ~flush & load[0];
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld     <= '0;
      seq_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        sign_q[k] <= '0;
        zero_q[k] <= '0;
        seq_q[k]  <= '0;
      end
    end else begin
      if (load[0]) begin
        vld[0]    <= accept;
        sign_q[0] <= lane_sign;
        zero_q[0] <= lane_zero;
        seq_q[0]  <= seq_cnt;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) begin
          vld[k]    <= vld[k-1];
          sign_q[k] <= sign_q[k-1];
          zero_q[k] <= zero_q[k-1];
          seq_q[k]  <= seq_q[k-1];
        end
      end
      // Data registers keep stale values; only the valids are dropped.
      if (flush) begin
        vld <= '0;
      end
      if (accept) begin
        seq_cnt <= seq_cnt + SEQW'(1);
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_sign  = sign_q[DEPTH-1];
  assign out_zero  = zero_q[DEPTH-1];
  assign out_seq   = seq_q[DEPTH-1];

endmodule

// File: tb/tb_booth_sign_pipe.sv
module tb_booth_sign_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        signed_mode;
  logic        flush;
  logic        out_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic        in_ready;
  logic        out_valid;
  logic [3:0]  out_sign;
  logic [3:0]  out_zero;
  logic [7:0]  out_seq;

  logic        w_in_ready;
  logic        w_out_valid;
  logic [3:0]  w_out_sign;
  logic [3:0]  w_out_zero;
  logic [1:0]  w_out_seq;

  int tests = 0;
  int fails = 0;

  logic [31:0] ta [5];
  logic [31:0] tb [5];
  logic        tm [5];
  logic [3:0]  es [5];
  logic [3:0]  ez [5];

  booth_sign_pipe #(.LANES(4), .W(8), .DEPTH(3), .SEQW(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .signed_mode(signed_mode), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_zero(out_zero), .out_seq(out_seq)
  );

  booth_sign_pipe #(.LANES(4), .W(8), .DEPTH(3), .SEQW(2)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .signed_mode(signed_mode), .flush(flush),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_sign(w_out_sign),
    .out_zero(w_out_zero), .out_seq(w_out_seq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drive(input int i);
    in_a        = ta[i];
    in_b        = tb[i];
    signed_mode = tm[i];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_in;
    int n_out;
    logic acc;

    // lanes listed lane3..lane0
    ta[0] = 32'h01_FF_00_80; tb[0] = 32'h01_01_05_7F; tm[0] = 1'b1; es[0] = 4'b0101; ez[0] = 4'b0010;
    ta[1] = 32'hFF_FF_FF_FF; tb[1] = 32'hFF_FF_FF_FF; tm[1] = 1'b1; es[1] = 4'b0000; ez[1] = 4'b0000;
    ta[2] = 32'h00_00_00_00; tb[2] = 32'h80_80_80_80; tm[2] = 1'b1; es[2] = 4'b0000; ez[2] = 4'b1111;
    ta[3] = 32'h80_01_80_01; tb[3] = 32'h01_80_80_01; tm[3] = 1'b1; es[3] = 4'b1100; ez[3] = 4'b0000;
    ta[4] = 32'h80_01_80_01; tb[4] = 32'h01_80_80_01; tm[4] = 1'b0; es[4] = 4'b0000; ez[4] = 4'b0000;

    in_a = '0;
    in_b = '0;
    signed_mode = 1'b0;
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_sign", out_sign, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_seq", out_seq, 0);

    // signed basic
    in_a = 32'h7F_00_80_F6;
    in_b = 32'hFF_FF_80_05;
    signed_mode = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("sb_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    step();
    chk("sb_not_early", out_valid, 0);
    step();
    chk("sb_valid", out_valid, 1);
    chk("sb_sign", out_sign, 4'b1001);
    chk("sb_zero", out_zero, 4'b0100);
    chk("sb_seq", out_seq, 0);

    // unsigned mode, same operands
    signed_mode = 1'b0;
    in_valid = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("us_valid", out_valid, 1);
    chk("us_sign", out_sign, 4'b0000);
    chk("us_zero", out_zero, 4'b0100);
    chk("us_seq", out_seq, 1);

    // backpressure: fill with out_ready low, then drain
    do_reset();
    out_ready = 1'b0;
    n_in = 0;
    for (int c = 0; c < 5; c++) begin
      drive(n_in);
      in_valid = 1'b1;
      #1;
      chk("bp_in_ready", in_ready, (c < 3) ? 1 : 0);
      if (c >= 3) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_seq", out_seq, 0);
        chk("bp_hold_sign", out_sign, es[0]);
        chk("bp_hold_zero", out_zero, ez[0]);
      end
      if (in_ready) n_in++;
      step();
    end
    out_ready = 1'b1;
    drive(n_in);
    #1;
    chk("bp_release_ready", in_ready, 1);
    n_out = 0;
    for (int c = 0; c < 20 && n_out < 5; c++) begin
      if (n_in < 5) begin
        drive(n_in);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid & in_ready;
      if (out_valid && out_ready) begin
        chk("bp_seq", out_seq, n_out);
        chk("bp_sign", out_sign, es[n_out]);
        chk("bp_zero", out_zero, ez[n_out]);
        n_out++;
      end
      step();
      if (acc) n_in++;
    end
    in_valid = 1'b0;
    chk("bp_count", n_out, 5);

    // flush mid-stream
    do_reset();
    out_ready = 1'b1;
    drive(1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      step();
    end
    flush = 1'b1;
    drive(0);
    #1;
    chk("fl_in_ready", in_ready, 0);
    chk("fl_out_valid", out_valid, 1);
    chk("fl_out_seq", out_seq, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_cleared", out_valid, 0);
    in_valid = 1'b1;
    #1;
    chk("fl_ready_again", in_ready, 1);
    step();
    in_valid = 1'b0;
    step();
    chk("fl_empty", out_valid, 0);
    step();
    chk("fl_valid", out_valid, 1);
    chk("fl_seq", out_seq, 3);
    chk("fl_sign", out_sign, es[0]);
    chk("fl_zero", out_zero, ez[0]);

    // reset mid-operation
    do_reset();
    out_ready = 1'b0;
    drive(3);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("rm_full_ready", in_ready, 0);
    chk("rm_full_valid", out_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("rm_valid", out_valid, 0);
    chk("rm_sign", out_sign, 0);
    chk("rm_zero", out_zero, 0);
    chk("rm_seq", out_seq, 0);
    drive(0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("rm_next_valid", out_valid, 1);
    chk("rm_next_seq", out_seq, 0);
    chk("rm_next_sign", out_sign, es[0]);

    // tag wrap on the 2-bit counter instance
    do_reset();
    out_ready = 1'b1;
    drive(3);
    for (int c = 0; c < 9; c++) begin
      in_valid = (c < 6);
      #1;
      if (c >= 3) begin
        chk("tw_valid", w_out_valid, 1);
        chk("tw_seq", w_out_seq, (c - 3) % 4);
        chk("tw_sign", w_out_sign, es[3]);
        chk("tw_seq8", out_seq, c - 3);
      end
      step();
    end
    chk("tw_drained", w_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
